// File: rtl/rv_fetch_ctrl.sv
// Instruction-fetch controller: one outstanding word read on the instruction bus,
// halfword pushes into the fetch buffer, flush and redirect on PC change.
module rv_fetch_ctrl #(
   parameter int unsigned IADDR_SPACE_BITS = 16,
   parameter int unsigned RESET_ADDR       = 0
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic                          i_pc_change,
   input  logic [IADDR_SPACE_BITS-1:1]   i_pc_target,
   output logic                          o_instr_req,
   output logic [IADDR_SPACE_BITS-1:2]   o_instr_addr,
   input  logic                          i_instr_gnt,
   input  logic                          i_instr_rvalid,
   input  logic [31:0]                   i_instr_data,
   input  logic                          i_buf_not_full,
   output logic                          o_buf_reset_n,
   output logic [IADDR_SPACE_BITS-1:1]   o_buf_pc,
   output logic                          o_push_single,
   output logic                          o_push_double,
   output logic [15:0]                   o_data_lo,
   output logic [15:0]                   o_data_hi
);

   localparam logic [IADDR_SPACE_BITS-1:0] RST_FULL = IADDR_SPACE_BITS'(RESET_ADDR);
   localparam logic [IADDR_SPACE_BITS-1:2] WORD_ONE = (IADDR_SPACE_BITS-2)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DROP = 2'd3
   } state_e;

   state_e                        state_q, state_d;
   logic [IADDR_SPACE_BITS-1:1]   fa_q, fa_d;
   logic                          flush_q, flush_d;
   logic                          push_single, push_double;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         fa_q    <= RST_FULL[IADDR_SPACE_BITS-1:1];
         flush_q <= 1'b1;
      end else begin
         state_q <= state_d;
         fa_q    <= fa_d;
         flush_q <= flush_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      fa_d        = fa_q;
      flush_d     = i_pc_change;
      push_single = 1'b0;
      push_double = 1'b0;
      if (i_pc_change) begin
         fa_d = i_pc_target;
      end
      unique case (state_q)
         IDLE: begin
            if (i_buf_not_full && !flush_q && !i_pc_change) begin
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (i_instr_gnt) begin
               state_d = i_pc_change ? DROP : DATA;
            end else if (i_pc_change) begin
               state_d = IDLE;
            end
         end
         DATA: begin
            if (i_instr_rvalid) begin
               state_d = IDLE;
               if (!i_pc_change) begin
                  // Odd halfword start: only the upper half belongs to the stream.
                  push_single = fa_q[1];
                  push_double = !fa_q[1];
                  fa_d        = {fa_q[IADDR_SPACE_BITS-1:2] + WORD_ONE, 1'b0};
               end
            end else if (i_pc_change) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (i_instr_rvalid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_instr_req   = (state_q == ADDR);
   assign o_instr_addr  = fa_q[IADDR_SPACE_BITS-1:2];
   assign o_buf_reset_n = !flush_q;
   assign o_buf_pc      = fa_q;
   assign o_push_single = push_single && !flush_q;
   assign o_push_double = push_double && !flush_q;
   assign o_data_lo     = i_instr_data[15:0];
   assign o_data_hi     = i_instr_data[31:16];

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Scoreboard bench for rv_fetch_ctrl: a bus responder model, directed scenarios that
// queue hand-computed expectations, and a monitor that pops them as the DUT responds.
module tb_rv_fetch_ctrl;

   localparam int unsigned AW = 16;

   logic          clk = 1'b0;
   logic          i_reset_n;
   logic          i_pc_change;
   logic [AW-1:1] i_pc_target;
   logic          o_instr_req;
   logic [AW-1:2] o_instr_addr;
   logic          i_instr_gnt;
   logic          i_instr_rvalid;
   logic [31:0]   i_instr_data;
   logic          i_buf_not_full;
   logic          o_buf_reset_n;
   logic [AW-1:1] o_buf_pc;
   logic          o_push_single;
   logic          o_push_double;
   logic [15:0]   o_data_lo;
   logic [15:0]   o_data_hi;

   always #5 clk = ~clk;

   rv_fetch_ctrl #(
      .IADDR_SPACE_BITS(AW),
      .RESET_ADDR      (32'h0100)
   ) dut (
      .i_clk         (clk),
      .i_reset_n     (i_reset_n),
      .i_pc_change   (i_pc_change),
      .i_pc_target   (i_pc_target),
      .o_instr_req   (o_instr_req),
      .o_instr_addr  (o_instr_addr),
      .i_instr_gnt   (i_instr_gnt),
      .i_instr_rvalid(i_instr_rvalid),
      .i_instr_data  (i_instr_data),
      .i_buf_not_full(i_buf_not_full),
      .o_buf_reset_n (o_buf_reset_n),
      .o_buf_pc      (o_buf_pc),
      .o_push_single (o_push_single),
      .o_push_double (o_push_double),
      .o_data_lo     (o_data_lo),
      .o_data_hi     (o_data_hi)
   );

   typedef struct {
      bit          single;
      logic [15:0] lo;
      logic [15:0] hi;
   } push_t;

   logic [13:0] exp_addr[$];
   logic [14:0] exp_flush[$];
   push_t       exp_push[$];

   int n_total = 0;
   int n_pass  = 0;
   int gnt_wait = 0;
   int rv_lat   = 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
   endtask

   // Bus responder: grants after gnt_wait cycles of req, returns data rv_lat cycles later.
   int          gcnt   = 0;
   int          rv_cnt = 0;
   logic [13:0] rv_addr = '0;
   always @(posedge clk) begin
      #1;
      i_instr_gnt    = 1'b0;
      i_instr_rvalid = 1'b0;
      if (!i_reset_n) begin
         gcnt   = 0;
         rv_cnt = 0;
      end else begin
         if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
               i_instr_rvalid = 1'b1;
               i_instr_data   = {16'hB000 + {2'b00, rv_addr}, 16'hA000 + {2'b00, rv_addr}};
            end
         end
         if (o_instr_req) begin
            if (gcnt >= gnt_wait) begin
               i_instr_gnt = 1'b1;
               gcnt        = 0;
               rv_cnt      = rv_lat;
               rv_addr     = o_instr_addr;
            end else begin
               gcnt++;
            end
         end else begin
            gcnt = 0;
         end
      end
   end

   // Monitor: compares every push, flush cycle and granted address against the queues.
   push_t       e;
   logic [14:0] ef;
   logic [13:0] ea;
   always @(negedge clk) begin
      if (o_push_single || o_push_double) begin
         check("push_exclusive", {31'b0, o_push_single & o_push_double}, 32'd0);
         if (exp_push.size() == 0) begin
            n_total++;
            $display("FAIL push_unexpected: got push single=%0b double=%0b, required none at %0t",
                     o_push_single, o_push_double, $time);
         end else begin
            e = exp_push.pop_front();
            check("push_single", {31'b0, o_push_single}, {31'b0, e.single});
            check("push_double", {31'b0, o_push_double}, {31'b0, !e.single});
            check("data_lo", {16'b0, o_data_lo}, {16'b0, e.lo});
            check("data_hi", {16'b0, o_data_hi}, {16'b0, e.hi});
         end
      end
      if (i_reset_n && !o_buf_reset_n) begin
         if (exp_flush.size() == 0) begin
            n_total++;
            $display("FAIL flush_unexpected: got flush with pc 0x%0h, required none at %0t",
                     o_buf_pc, $time);
         end else begin
            ef = exp_flush.pop_front();
            check("flush_pc", {17'b0, o_buf_pc}, {17'b0, ef});
         end
      end
      if (o_instr_req && i_instr_gnt) begin
         if (exp_addr.size() == 0) begin
            n_total++;
            $display("FAIL addr_unexpected: got request 0x%0h, required none at %0t",
                     o_instr_addr, $time);
         end else begin
            ea = exp_addr.pop_front();
            check("req_addr", {18'b0, o_instr_addr}, {18'b0, ea});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit queues_empty();
      return (exp_addr.size() == 0) && (exp_flush.size() == 0) && (exp_push.size() == 0);
   endfunction

   task automatic drain(input string name, input int budget);
      int b = budget;
      while (!queues_empty() && b > 0) begin
         tick();
         b--;
      end
      n_total++;
      if (queues_empty()) n_pass++;
      else begin
         $display("FAIL %s_drain: got %0d/%0d/%0d pending addr/flush/push, required 0/0/0",
                  name, exp_addr.size(), exp_flush.size(), exp_push.size());
         exp_addr.delete();
         exp_flush.delete();
         exp_push.delete();
      end
      i_buf_not_full = 1'b0;
      repeat (2) tick();
   endtask

   task automatic wait_req(input string name, input int budget);
      int b = budget;
      while (!o_instr_req && b > 0) begin
         tick();
         b--;
      end
      if (!o_instr_req) begin
         n_total++;
         $display("FAIL %s_req_timeout: got req=0, required req=1", name);
      end
   endtask

   task automatic pulse_pc(input logic [14:0] target);
      i_pc_change = 1'b1;
      i_pc_target = target;
      tick();
      i_pc_change = 1'b0;
   endtask

   task automatic exp_word(input logic [13:0] w, input bit single);
      push_t p;
      p.single = single;
      p.lo     = 16'hA000 + {2'b00, w};
      p.hi     = 16'hB000 + {2'b00, w};
      exp_addr.push_back(w);
      exp_push.push_back(p);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_req"},      {31'b0, o_instr_req},   32'd0);
      check({name, "_single"},   {31'b0, o_push_single}, 32'd0);
      check({name, "_double"},   {31'b0, o_push_double}, 32'd0);
      check({name, "_buf_rstn"}, {31'b0, o_buf_reset_n}, 32'd0);
      check({name, "_buf_pc"},   {17'b0, o_buf_pc},      32'h080);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_reset_n      = 1'b0;
      i_pc_change    = 1'b0;
      i_pc_target    = '0;
      i_instr_gnt    = 1'b0;
      i_instr_rvalid = 1'b0;
      i_instr_data   = '0;
      i_buf_not_full = 1'b1;

      // Reset from 0x0100, three zero-wait fetches.
      repeat (2) tick();
      @(negedge clk);
      check_reset_outputs("rst");
      exp_flush.push_back(15'h080);
      exp_word(14'h040, 1'b0);
      exp_word(14'h041, 1'b0);
      exp_word(14'h042, 1'b0);
      tick();
      i_reset_n = 1'b1;
      drain("boot", 60);

      // Redirect to odd halfword 0x0106.
      exp_flush.push_back(15'h083);
      exp_word(14'h041, 1'b1);
      exp_word(14'h042, 1'b0);
      i_buf_not_full = 1'b1;
      pulse_pc(15'h083);
      drain("redirect", 60);

      // Redirect while in DATA, response 4 cycles after grant.
      rv_lat = 4;
      exp_addr.push_back(14'h043);
      exp_flush.push_back(15'h100);
      exp_word(14'h080, 1'b0);
      i_buf_not_full = 1'b1;
      wait_req("data_redir", 20);
      tick();
      pulse_pc(15'h100);
      drain("data_redir", 60);

      // Redirect in the grant cycle.
      rv_lat = 2;
      exp_addr.push_back(14'h081);
      exp_flush.push_back(15'h180);
      exp_word(14'h0C0, 1'b0);
      exp_word(14'h0C1, 1'b0);
      i_buf_not_full = 1'b1;
      wait_req("gnt_redir", 20);
      pulse_pc(15'h180);
      drain("gnt_redir", 60);

      // Redirect while the request is still waiting for grant.
      rv_lat   = 1;
      gnt_wait = 3;
      exp_flush.push_back(15'h020);
      exp_word(14'h010, 1'b0);
      i_buf_not_full = 1'b1;
      wait_req("withdraw", 20);
      pulse_pc(15'h020);
      drain("withdraw", 60);
      gnt_wait = 0;

      // Buffer full for 10 cycles in IDLE.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("full_hold_req", {31'b0, o_instr_req}, 32'd0);
      end
      tick();
      exp_word(14'h011, 1'b0);
      i_buf_not_full = 1'b1;
      @(negedge clk);
      check("full_release_req0", {31'b0, o_instr_req}, 32'd0);
      @(negedge clk);
      check("full_release_req1", {31'b0, o_instr_req}, 32'd1);
      drain("full", 60);

      // Reset asserted while in DATA.
      rv_lat = 3;
      exp_addr.push_back(14'h012);
      i_buf_not_full = 1'b1;
      wait_req("mid_reset", 20);
      tick();
      i_reset_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      exp_flush.push_back(15'h080);
      exp_word(14'h040, 1'b0);
      tick();
      tick();
      i_reset_n = 1'b1;
      drain("mid_reset", 60);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
